// File: rtl/alu_pkg.sv
// Shared op encodings, flag bit positions and the per-op flag write mask
// for the pipelined ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_RED    = 3'b010,
        OP_XOR    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } op_t;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    function automatic logic [2:0] flag_mask(input op_t op);
        logic [2:0] m;
        m = '0;
        unique case (op)
            OP_ADD, OP_SUB: begin
                m[FLAG_N] = 1'b1;
                m[FLAG_Z] = 1'b1;
                m[FLAG_V] = 1'b1;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLAG_Z] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result and NZV for one operand pair.
// Sits between the S1 operand registers and the S2 result registers.
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  op_t              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res,
    output logic [2:0]       o_nzv
);

    localparam int SHW = $clog2(WIDTH);
    localparam int NL  = WIDTH / LANE;
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
    localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

    logic [SHW-1:0]   w_amt;
    logic [SHW-1:0]   w_namt;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_dif;
    logic             w_add_ov;
    logic             w_sub_ov;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_pad;
    logic [LANE:0]    w_ls;
    logic             w_v;

    assign w_amt  = i_b[SHW-1:0];
    assign w_namt = SHW'(0) - w_amt;

    // One guard bit: overflow shows as disagreement of the top two bits.
    assign w_sum    = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
    assign w_dif    = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    assign w_add_ov = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_sub_ov = w_dif[WIDTH] ^ w_dif[WIDTH-1];
    assign w_add    = w_add_ov ? (w_sum[WIDTH] ? SMIN : SMAX)
                               : w_sum[WIDTH-1:0];
    assign w_sub    = w_sub_ov ? (w_dif[WIDTH] ? SMIN : SMAX)
                               : w_dif[WIDTH-1:0];

    assign w_sra = $signed(i_a) >>> w_amt;
    assign w_ror = (i_a >> w_amt) | (i_a << w_namt);

    always_comb begin
        w_acc = '0;
        w_pad = '0;
        w_ls  = '0;
        for (int l = 0; l < NL; l++) begin
            w_acc = w_acc + WIDTH'($signed(i_a[l*LANE +: LANE]));
            w_acc = w_acc + WIDTH'($signed(i_b[l*LANE +: LANE]));
            w_ls  = {i_a[l*LANE+LANE-1], i_a[l*LANE +: LANE]}
                  + {i_b[l*LANE+LANE-1], i_b[l*LANE +: LANE]};
            w_pad[l*LANE +: LANE] = (w_ls[LANE] ^ w_ls[LANE-1])
                                  ? (w_ls[LANE] ? LMIN : LMAX)
                                  : w_ls[LANE-1:0];
        end
    end

    always_comb begin
        o_res = '0;
        w_v   = 1'b0;
        unique case (i_op)
            OP_ADD: begin
                o_res = w_add;
                w_v   = w_add_ov;
            end
            OP_SUB: begin
                o_res = w_sub;
                w_v   = w_sub_ov;
            end
            OP_RED:    o_res = w_acc;
            OP_XOR:    o_res = i_a ^ i_b;
            OP_SLL:    o_res = i_a << w_amt;
            OP_SRA:    o_res = w_sra;
            OP_ROR:    o_res = w_ror;
            OP_PADDSB: o_res = w_pad;
        endcase
    end

    always_comb begin
        o_nzv         = '0;
        o_nzv[FLAG_N] = o_res[WIDTH-1];
        o_nzv[FLAG_Z] = (o_res == '0);
        o_nzv[FLAG_V] = w_v;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and an
// architectural NZV register written in order at result acceptance.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_flag,
    output logic [2:0]       flag
);

    logic             r_s1_valid;
    op_t              r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_res;
    logic [2:0]       r_s2_nzv;
    logic [2:0]       r_s2_mask;
    logic [2:0]       r_flag;

    logic             w_s1_adv;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_res;
    logic [2:0]       w_nzv;

    assign w_s1_adv   = !r_s2_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s1_adv;
    assign w_out_fire = r_s2_valid && out_ready;

    alu_pipe_core #(
        .WIDTH (WIDTH),
        .LANE  (LANE)
    ) u_core (
        .i_op  (r_s1_op),
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .o_res (w_res),
        .o_nzv (w_nzv)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_nzv   <= '0;
            r_s2_mask  <= '0;
            r_flag     <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_op <= op_t'(in_op);
                    r_s1_a  <= in_a;
                    r_s1_b  <= in_b;
                end
            end
            if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_res  <= w_res;
                    r_s2_nzv  <= w_nzv;
                    r_s2_mask <= flag_mask(r_s1_op);
                end
            end
            // Only accepted results touch the flags, so order is preserved.
            if (w_out_fire) begin
                r_flag <= (r_flag & ~r_s2_mask) | (r_s2_nzv & r_s2_mask);
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_s2_res;
    assign out_flag   = r_s2_nzv;
    assign flag       = r_flag;

endmodule
